seq_det_rr_sched: RTL and testbench
===================================

// Module: seq_det_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one 4-bit symbol-sequence matcher among NCH
//  input channels.
//  - Per-channel match progress is held in context registers, so every channel
//    detects the pattern 1,0,2,2,1,0 on its own symbol stream.
//  - Sits between the symbol sources and the downstream event logic; the
//    match pulse is tagged with the channel id.
// PARAMETERS
//  NCH    4    number of requesting channels (2..8)
//  CHW    2    channel id width, $clog2(NCH)
//  CNTW   8    width of per-channel match counters (MATCH_CNT_EN only)
// PORTS
//  clk         in   1        clock, all state updates on posedge
//  rst         in   1        synchronous active-high reset
//  in_valid    in   NCH      per-channel symbol valid
//  in_sym      in   4*NCH    per-channel symbol; channel i = in_sym[4*i+3:4*i]
//  in_ready    out  NCH      one-hot grant; symbol accepted when valid&ready
//  ch_clr      in   NCH      per-channel progress clear (context -> 0)
//  match_valid out  1        one-cycle pulse: full pattern completed
//  match_ch    out  CHW      channel that completed the pattern
//  rd_ch       in   CHW      counter read select (MATCH_CNT_EN only)
//  rd_cnt      out  CNTW     match count of channel rd_ch (MATCH_CNT_EN only)
// BEHAVIOUR
//  - Reset: ptr=0, all ctx=0, match_valid=0, match_ch=0, counters=0.
//  - Arbiter:
//    - in_ready is combinational: one-hot, for the first valid channel at or
//      after ptr, in ascending order with wrap NCH-1 -> 0.
//    - in_ready = 0 when no channel is valid.
//    - in_ready is 0 during rst.
//    - After a grant to channel g, ptr <= (g+1) mod NCH.
//    - With no grant, ptr holds.
//    - At most one accept per cycle.
//    - A channel granted with valid held high is granted again only after the
//      other valid channels have been served.
//  - Matcher: ctx[g] (0..5) = number of pattern symbols matched; x = accepted symbol.
//    - P0: x=1 -> 1, else 0.
//    - P1: x=0 -> 2; x=1 -> 1; else 0.
//    - P2: x=2 -> 3; x=1 -> 1; else 0.
//    - P3: x=2 -> 4; x=1 -> 1; else 0.
//    - P4: x=1 -> 5, else 0.
//    - P5: x=0 -> match, ctx <= 2 (overlap keeps the "1,0"); x=1 -> 1; else 0.
//  - Output:
//    - match_valid and match_ch are registered, 1 cycle after the accept of
//      the final 0.
//    - match_valid is 0 in all other cycles.
//    - match_ch holds its last value when match_valid=0.
//  - Boundary conditions:
//    - Contexts of non-granted channels never change, except via ch_clr.
//    - ch_clr[i] sets ctx[i]=0 on the next edge.
//    - ch_clr[i] in the same cycle as an accept on channel i: the clear wins,
//      the symbol is consumed (ready still 1) and ignored, and no match is
//      produced even if ctx was 5 and x=0.
//    - rst mid-stream aborts all progress; a pending match pulse is dropped.
//  - Symbols 3..15 behave as "else" in every state.
// CONFIGURATION
//  MATCH_CNT_EN defined:
//  - Per-channel CNTW-bit counter, incremented on each match of that channel.
//  - The counter saturates at all-ones.
//  - ch_clr does not clear the counters; only rst does.
//  - rd_cnt = cnt[rd_ch], combinational.
//  MATCH_CNT_EN undefined:
//  - No counters are built; rd_ch is ignored and rd_cnt is tied to 0.
//  - All other behaviour is identical.
// TESTING
//  - T1: ch0 only, symbols 1,0,2,2,1,0 -> match_valid=1, match_ch=0 one cycle
//    after the 6th accept.
//  - T2: then 2,2,1,0 on ch0 -> a second match (overlap from P2).
//  - T3: ch0..3 all valid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//  - T4: only ch1 and ch3 valid -> grants alternate 1,3,1,3.
//  - T5: interleave the pattern on ch2 with junk (5,7) on ch1 -> ch2 matches
//    (match_ch=2); ch1 never matches.
//  - T6: ch3 at P5, assert ch_clr[3] with x=0 accepted -> no match; next
//    2,2,1,0 gives no match.
//  - T7 (MATCH_CNT_EN): CNTW=2, 5 matches on ch0 -> rd_ch=0 gives rd_cnt=3;
//    rst -> rd_cnt=0.

Source files
------------

// File: rtl/seq_det_rr_sched_if.sv
// Symbol/grant/match bus between the channel sources and seq_det_rr_sched.
// Handshake: channel i transfers in_sym[4*i+3:4*i] on a rising edge where in_valid[i] && in_ready[i]; in_ready is one-hot or zero, and a source must not depend on in_ready to raise in_valid.
interface seq_det_rr_sched_if #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
);
    logic [NCH-1:0]   in_valid;
    logic [4*NCH-1:0] in_sym;
    logic [NCH-1:0]   in_ready;
    logic [NCH-1:0]   ch_clr;
    logic             match_valid;
    logic [CHW-1:0]   match_ch;

    modport master (
        output in_valid, in_sym, ch_clr,
        input  in_ready, match_valid, match_ch
    );

    modport slave (
        input  in_valid, in_sym, ch_clr,
        output in_ready, match_valid, match_ch
    );
endinterface

// File: rtl/seq_det_rr_sched.sv
// Round-robin scheduler sharing one 1,0,2,2,1,0 matcher across NCH channels via per-channel context.
// Optional per-channel saturating match counters are built when MATCH_CNT_EN is defined.
module seq_det_rr_sched #(
    parameter int NCH  = 4,
    parameter int CHW  = $clog2(NCH),
    parameter int CNTW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seq_det_rr_sched_if.slave     bus,
    input  logic [CHW-1:0]        i_rd_ch,
    output logic [CNTW-1:0]       o_rd_cnt,
    output logic [CHW-1:0]        o_dbg_ptr,
    output logic [3*NCH-1:0]      o_dbg_ctx
);
    typedef enum logic [2:0] {P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4, P5 = 3'd5} ctx_t;

    ctx_t           r_ctx [NCH];
    logic [CHW-1:0] r_ptr;
    logic           r_match_valid;
    logic [CHW-1:0] r_match_ch;

    logic [NCH-1:0] w_grant;
    logic           w_any;
    logic [CHW-1:0] w_gidx;
    logic [CHW:0]   w_dist;
    logic [CHW:0]   w_best;
    ctx_t           w_cur;
    logic [3:0]     w_x;
    logic           w_clr_g;
    ctx_t           w_step;
    logic           w_step_match;
    logic           w_match;
    ctx_t           w_ctx_nxt [NCH];
    logic [CHW-1:0] w_ptr_nxt;

    // Pick the valid channel with the smallest rotated distance from r_ptr.
    always_comb begin
        w_any  = (|bus.in_valid) && !i_rst;
        w_gidx = '0;
        w_dist = '0;
        w_best = (CHW+1)'(NCH);
        for (int i = 0; i < NCH; i++) begin
            if (bus.in_valid[i]) begin
                w_dist = (CHW+1)'(i) + (CHW+1)'(NCH) - {1'b0, r_ptr};
                if (w_dist >= (CHW+1)'(NCH)) begin
                    w_dist = w_dist - (CHW+1)'(NCH);
                end
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_gidx = CHW'(i);
                end
            end
        end
        w_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            w_grant[i] = w_any && (w_gidx == CHW'(i));
        end
    end

    always_comb begin
        w_cur   = P0;
        w_x     = '0;
        w_clr_g = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gidx == CHW'(i)) begin
                w_cur   = r_ctx[i];
                w_x     = bus.in_sym[4*i +: 4];
                w_clr_g = bus.ch_clr[i];
            end
        end
    end

    // Matcher next state for the granted channel; P5 falls back to P2 so the trailing "1,0" is reused.
    always_comb begin
        w_step       = P0;
        w_step_match = 1'b0;
        case (w_cur)
            P0: w_step = (w_x == 4'd1) ? P1 : P0;
            P1: w_step = (w_x == 4'd0) ? P2 : (w_x == 4'd1) ? P1 : P0;
            P2: w_step = (w_x == 4'd2) ? P3 : (w_x == 4'd1) ? P1 : P0;
            P3: w_step = (w_x == 4'd2) ? P4 : (w_x == 4'd1) ? P1 : P0;
            P4: w_step = (w_x == 4'd1) ? P5 : P0;
            P5: begin
                if (w_x == 4'd0) begin
                    w_step       = P2;
                    w_step_match = 1'b1;
                end else if (w_x == 4'd1) begin
                    w_step = P1;
                end
            end
            default: w_step = P0;
        endcase
    end

    always_comb begin
        w_match = w_any && w_step_match && !w_clr_g;
        for (int i = 0; i < NCH; i++) begin
            w_ctx_nxt[i] = r_ctx[i];
            if (bus.ch_clr[i]) begin
                w_ctx_nxt[i] = P0;
            end else if (w_grant[i]) begin
                w_ctx_nxt[i] = w_step;
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_any) begin
            w_ptr_nxt = (w_gidx == CHW'(NCH-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr         <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= P0;
            end
        end else begin
            r_ptr         <= w_ptr_nxt;
            r_match_valid <= w_match;
            if (w_match) begin
                r_match_ch <= w_gidx;
            end
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= w_ctx_nxt[i];
            end
        end
    end

    assign bus.in_ready    = w_grant;
    assign bus.match_valid = r_match_valid;
    assign bus.match_ch    = r_match_ch;
    assign o_dbg_ptr       = r_ptr;

    always_comb begin
        o_dbg_ctx = '0;
        for (int i = 0; i < NCH; i++) begin
            o_dbg_ctx[3*i +: 3] = r_ctx[i];
        end
    end

`ifdef MATCH_CNT_EN
    logic [CNTW-1:0] r_cnt [NCH];

    // Counters survive ch_clr; only reset zeroes them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_match && (w_gidx == CHW'(i)) && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_rd_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_rd_ch == CHW'(i)) begin
                o_rd_cnt = r_cnt[i];
            end
        end
    end
`else
    logic w_unused_rd;
    assign w_unused_rd = ^i_rd_ch;
    assign o_rd_cnt    = '0;
`endif
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed vector bench for seq_det_rr_sched: arbitration order, pattern matching, clears and reset.
// Expected read-back counts depend on whether MATCH_CNT_EN is defined.
module tb_seq_det_rr_sched;
    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int CNTW = 2;

`ifdef MATCH_CNT_EN
    localparam logic [CNTW-1:0] CNT_EXP = 2'd3;
`else
    localparam logic [CNTW-1:0] CNT_EXP = 2'd0;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [15:0] sym;
        logic [3:0]  clr;
        logic [3:0]  ready;
        logic        mv;
        logic [1:0]  mch;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CHW-1:0]   rd_ch = '0;
    logic [CNTW-1:0]  rd_cnt;
    logic [CHW-1:0]   dbg_ptr;
    logic [3*NCH-1:0] dbg_ctx;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    seq_det_rr_sched_if #(.NCH(NCH), .CHW(CHW)) bus_if ();

    seq_det_rr_sched #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus_if),
        .i_rd_ch   (rd_ch),
        .o_rd_cnt  (rd_cnt),
        .o_dbg_ptr (dbg_ptr),
        .o_dbg_ctx (dbg_ctx)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [3:0] v, input logic [15:0] s,
                                input logic [3:0] c, input logic [3:0] rdy, input logic mv,
                                input logic [1:0] mch);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.sym   = s;
        t.clr   = c;
        t.ready = rdy;
        t.mv    = mv;
        t.mch   = mch;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [15:0] s, input logic [3:0] c);
        @(negedge clk);
        rst             = r;
        bus_if.in_valid = v;
        bus_if.in_sym   = s;
        bus_if.ch_clr   = c;
    endtask

    initial begin
        int pat[6];
        int tail[4];
        int mcount;

        pat  = '{1, 0, 2, 2, 1, 0};
        tail = '{2, 2, 1, 0};
        bus_if.in_valid = '0;
        bus_if.in_sym   = '0;
        bus_if.ch_clr   = '0;

        // reset with every channel requesting: no grant
        add(1'b1, 4'hF, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        // T1 and T2: channel 0 alone, full pattern then overlapped tail
        for (int k = 0; k < 6; k++) add(1'b0, 4'h1, 16'(pat[k]), 4'h0, 4'h1, k == 5, 2'd0);
        for (int k = 0; k < 4; k++) add(1'b0, 4'h1, 16'(tail[k]), 4'h0, 4'h1, k == 3, 2'd0);
        add(1'b1, 4'hF, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        // T3: all channels valid
        for (int k = 0; k < 8; k++) add(1'b0, 4'hF, 16'h0, 4'h0, 4'(1 << (k % 4)), 1'b0, 2'd0);
        // T4: channels 1 and 3 alternate
        for (int k = 0; k < 4; k++) add(1'b0, 4'hA, 16'h0, 4'h0, (k % 2 == 0) ? 4'h2 : 4'h8, 1'b0, 2'd0);
        // T5: channel 2 pattern interleaved with junk on channel 1
        for (int k = 0; k < 12; k++)
            add(1'b0, 4'h6, 16'((pat[k/2] << 8) | (((k % 4) < 2 ? 5 : 7) << 4)), 4'h0,
                (k % 2 == 0) ? 4'h2 : 4'h4, k == 11, (k == 11) ? 2'd2 : 2'd0);
        // T6: channel 3 reaches P5, clear wins over the final 0; channel 2 cleared while idle
        add(1'b0, 4'h8, 16'(1 << 12), 4'h4, 4'h8, 1'b0, 2'd2);
        for (int k = 1; k < 5; k++) add(1'b0, 4'h8, 16'(pat[k] << 12), 4'h0, 4'h8, 1'b0, 2'd2);
        add(1'b0, 4'h8, 16'h0, 4'h8, 4'h8, 1'b0, 2'd2);
        for (int k = 0; k < 4; k++) add(1'b0, 4'h8, 16'(tail[k] << 12), 4'h0, 4'h8, 1'b0, 2'd2);
        for (int k = 0; k < 4; k++) add(1'b0, 4'h4, 16'(tail[k] << 8), 4'h0, 4'h4, 1'b0, 2'd2);
        // reset just before the final 0 aborts the match
        for (int k = 0; k < 5; k++) add(1'b0, 4'h1, 16'(pat[k]), 4'h0, 4'h1, 1'b0, 2'd2);
        add(1'b1, 4'h1, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(1'b0, 4'h1, 16'h0, 4'h0, 4'h1, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].sym, vecs[i].clr);
            #1;
            check("in_ready", i, 32'(bus_if.in_ready), 32'(vecs[i].ready));
            @(posedge clk);
            #1;
            check("match_valid", i, 32'(bus_if.match_valid), 32'(vecs[i].mv));
            check("match_ch", i, 32'(bus_if.match_ch), 32'(vecs[i].mch));
        end

        // T7: five matches on channel 0, counter saturates at 3 with CNTW=2
        drive(1'b1, 4'h0, 16'h0, 4'h0);
        @(posedge clk);
        mcount = 0;
        for (int k = 0; k < 22; k++) begin
            drive(1'b0, 4'h1, (k < 6) ? 16'(pat[k]) : 16'(tail[(k - 6) % 4]), 4'h0);
            @(posedge clk);
            #1;
            if (bus_if.match_valid) mcount++;
        end
        check("t7_match_count", 0, 32'(mcount), 32'd5);
        drive(1'b0, 4'h0, 16'h0, 4'h0);
        rd_ch = 2'd0;
        #1;
        check("rd_cnt_ch0", 0, 32'(rd_cnt), 32'(CNT_EXP));
        rd_ch = 2'd1;
        #1;
        check("rd_cnt_ch1", 0, 32'(rd_cnt), 32'd0);
        drive(1'b0, 4'h0, 16'h0, 4'h1);
        @(posedge clk);
        rd_ch = 2'd0;
        #1;
        check("rd_cnt_after_clr", 0, 32'(rd_cnt), 32'(CNT_EXP));
        drive(1'b1, 4'h0, 16'h0, 4'h0);
        @(posedge clk);
        #1;
        check("rd_cnt_after_rst", 0, 32'(rd_cnt), 32'd0);
        check("ptr_after_rst", 0, 32'(dbg_ptr), 32'd0);
        check("ctx_after_rst", 0, 32'(dbg_ctx), 32'd0);
        drive(1'b0, 4'h0, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
